pwm_deadtime: RTL and testbench
===============================

Name: pwm_deadtime

Overview:
Dead-time insertion stage directly downstream of the PWM compare stage. Consumes the single-ended raw PWM and drives a complementary high-side/low-side gate pair. A programmable dead interval, with both outputs low, separates every turn-off of one side from the turn-on of the other. Outputs are registered and can never be high simultaneously.

Parameters:
DT_WIDTH, 16, width of the dead-time count in clk cycles.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  synchronous run enable; 0 forces both outputs low.
pwm_raw  input  1  raw PWM from the compare stage, same clk domain.
deadtime_cycles  input  DT_WIDTH  requested dead time in clk cycles.
out_h  output  1  high-side gate drive, registered.
out_l  output  1  low-side gate drive, registered.
dt_active  output  1  high while a dead interval is in progress, registered.

Behaviour:
- Reset (async, rst=1): state=IDLE, out_h=0, out_l=0, dt_active=0, counter=0, target=0. Outputs go low immediately, without waiting for a clock edge.
- D_eff = max(deadtime_cycles, 1). Zero is clamped to 1, so there is never a same-edge side swap.
- deadtime_cycles is sampled only when DEAD is entered. Changes during DEAD take effect on the next dead interval.
- Outputs are decoded from the registered state:
  - out_h = (state==HIGH)
  - out_l = (state==LOW)
  - dt_active = (state==DEAD)
- States: IDLE, DEAD, HIGH, LOW. enable=0 on any edge forces the next state to IDLE and clears the counter. This has priority over every other transition.
- IDLE, enable=1: enter DEAD, target=pwm_raw, counter=D_eff-1. A startup dead interval is always inserted.
- HIGH, pwm_raw=0 sampled at edge k: enter DEAD at edge k, target=0, counter=D_eff-1. out_h falls after edge k.
- LOW, pwm_raw=1 sampled at edge k: mirror case, target=1.
- HIGH with pwm_raw=1, or LOW with pwm_raw=0: hold.
- DEAD, each edge:
  - target <= pwm_raw. Target tracks the input; the counter is not reloaded.
  - counter != 0: decrement.
  - counter == 0: enter HIGH if the updated target=1, else LOW.
- Timing contract: both outputs are low for exactly D_eff clk cycles. The new side asserts after edge k+D_eff.
- Pulses on pwm_raw shorter than D_eff are absorbed. The output follows the input level present when the counter expires. This minimum-pulse behaviour is intended.
- pwm_raw returning to the previous level during DEAD: the previous side re-asserts after the full D_eff. This is safe because the opposite side never turned on.
- Invariant (assert in RTL sim): never (out_h && out_l).
- Counter is DT_WIDTH bits. D_eff-1 cannot underflow because D_eff ≥ 1. With deadtime_cycles = 2^DT_WIDTH-1, the dead interval is the maximum 2^DT_WIDTH-1 cycles.
- enable falling mid-DEAD or mid-HIGH/LOW: IDLE on the next edge, both outputs low after that edge.
- enable rising while pwm_raw toggles: target captures pwm_raw at the IDLE→DEAD edge, then tracks it as above.

Decomposition:
- Package pwm_pkg holds:
  - typedef enum logic [1:0] pwm_dt_state_t {IDLE, DEAD, HIGH, LOW}.
  - localparam PWM_DT_MIN = 1.
- Single module with no sub-module. The down-counter is inline (about 10 lines) and not worth a separate block.

Test Plan:
1. Reset asserted asynchronously mid-HIGH, between edges: out_h drops before the next edge, with out_l=0 and dt_active=0.
2. deadtime_cycles=4, enable=1, pwm_raw steady 1 from IDLE: 4 cycles with dt_active=1 and both outputs low, then out_h=1. pwm_raw→0 at edge k: out_h=0 after k, out_l=1 after k+4.
3. deadtime_cycles=0, pwm_raw toggling every 10 cycles: exactly 1 dead cycle at each transition; never both outputs high.
4. deadtime_cycles=5, HIGH, pwm_raw low for 2 cycles then back high: out_h low for 5 cycles, re-asserts, and out_l never asserts.
5. deadtime_cycles changed from 3 to 8 during a dead interval: the current interval lasts 3 cycles, the next lasts 8.
6. enable→0 during DEAD with counter=2: IDLE on the next edge with all outputs low. enable→1 with pwm_raw=0: full D_eff dead interval, then out_l=1.

Source files
------------

// File: rtl/pwm_deadtime_pkg.sv
// Shared types and constants for the PWM dead-time insertion stage.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_dt_state_t;

    localparam int unsigned PWM_DT_MIN = 1;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion: turns a raw PWM into a complementary high/low gate pair
// with a programmable both-low interval between every side change.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                pwm_raw,
    input  logic [DT_WIDTH-1:0] deadtime_cycles,
    output logic                out_h,
    output logic                out_l,
    output logic                dt_active
);

    pwm_dt_state_t       state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                tgt_q, tgt_d;
    logic                out_h_q, out_l_q, dt_active_q;
    logic [DT_WIDTH-1:0] load_val;

    // Counter is loaded with D_eff-1; a zero request is clamped to the minimum.
    always_comb begin
        if (deadtime_cycles < DT_WIDTH'(PWM_DT_MIN))
            load_val = DT_WIDTH'(PWM_DT_MIN - 1);
        else
            load_val = deadtime_cycles - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = DEAD;
                    tgt_d   = pwm_raw;
                    cnt_d   = load_val;
                end
                HIGH: begin
                    if (!pwm_raw) begin
                        state_d = DEAD;
                        tgt_d   = 1'b0;
                        cnt_d   = load_val;
                    end
                end
                LOW: begin
                    if (pwm_raw) begin
                        state_d = DEAD;
                        tgt_d   = 1'b1;
                        cnt_d   = load_val;
                    end
                end
                DEAD: begin
                    // Target follows the input; the side is chosen only on expiry.
                    tgt_d = pwm_raw;
                    if (cnt_q != '0)
                        cnt_d = cnt_q - 1'b1;
                    else
                        state_d = pwm_raw ? HIGH : LOW;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tgt_q       <= 1'b0;
            out_h_q     <= 1'b0;
            out_l_q     <= 1'b0;
            dt_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            out_h_q     <= (state_d == HIGH);
            out_l_q     <= (state_d == LOW);
            dt_active_q <= (state_d == DEAD);
        end
    end

    assign out_h     = out_h_q;
    assign out_l     = out_l_q;
    assign dt_active = dt_active_q;

    a_no_shoot_through: assert property (@(posedge clk) disable iff (rst) !(out_h_q && out_l_q));

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized and directed bench for pwm_deadtime against a cycle-level
// behavioural model of the dead-time rules.
module tb_pwm_deadtime;

    localparam int unsigned DTW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           pwm_raw = 1'b0;
    logic [DTW-1:0] deadtime_cycles = '0;
    logic           out_h, out_l, dt_active;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: dead_left = remaining both-low cycles, act = a side is driven.
    int m_dead_left = 0;
    bit m_act  = 1'b0;
    bit m_side = 1'b0;

    pwm_deadtime #(.DT_WIDTH(DTW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .pwm_raw         (pwm_raw),
        .deadtime_cycles (deadtime_cycles),
        .out_h           (out_h),
        .out_l           (out_l),
        .dt_active       (dt_active)
    );

    always #5 clk = ~clk;

    function automatic int deff();
        return (deadtime_cycles == 0) ? 1 : int'(deadtime_cycles);
    endfunction

    function automatic logic [2:0] obs();
        return {out_h, out_l, dt_active};
    endfunction

    function automatic logic [2:0] expv();
        return {m_act && m_side, m_act && !m_side, m_dead_left != 0};
    endfunction

    task automatic model_reset();
        m_dead_left = 0;
        m_act       = 1'b0;
        m_side      = 1'b0;
    endtask

    // Advance one edge and update the model from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (!enable) begin
            m_act       = 1'b0;
            m_dead_left = 0;
        end else if (!m_act && m_dead_left == 0) begin
            m_dead_left = deff();
        end else if (m_dead_left > 0) begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                m_act  = 1'b1;
                m_side = pwm_raw;
            end
        end else if (pwm_raw != m_side) begin
            m_act       = 1'b0;
            m_dead_left = deff();
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        model_reset();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1; pwm_raw = 1'b1; deadtime_cycles = 16'd2;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (obs() !== 3'b100) $display("FAIL reset_setup_high: got %b expected 100", obs());
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== 3'b000) $display("FAIL reset_async: got h/l/dt=%b expected 000", obs());
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== 3'b000) $display("FAIL reset_held: got h/l/dt=%b expected 000", obs());
        else n_pass++;
        rst = 1'b0;
        enable = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int len;
        enable = 1'b1; pwm_raw = 1'b1; deadtime_cycles = 16'd4;
        len = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) $display("FAIL basic_start: got %b expected %b", obs(), expv());
            else n_pass++;
            if (dt_active) len++;
            if (out_h) break;
        end
        n_checks++;
        if (len != 4 || out_h !== 1'b1) $display("FAIL basic_start_len: got len=%0d h=%b expected len=4 h=1", len, out_h);
        else n_pass++;
        pwm_raw = 1'b0;
        tick();
        n_checks++;
        if (obs() !== 3'b001) $display("FAIL basic_fall_k: got %b expected 001", obs());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (obs() !== ((i == 3) ? 3'b010 : 3'b001))
                $display("FAIL basic_fall_k%0d: got %b expected %b", i + 1, obs(), (i == 3) ? 3'b010 : 3'b001);
            else n_pass++;
        end
    endtask

    task automatic test_zero_dt();
        int run = 0;
        deadtime_cycles = '0;
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0) pwm_raw = ~pwm_raw;
            tick();
            n_checks++;
            if (obs() !== expv() || (out_h && out_l)) $display("FAIL zero_dt: got %b expected %b", obs(), expv());
            else n_pass++;
            if (dt_active) run++;
            else if (run != 0) begin
                n_checks++;
                if (run != 1) $display("FAIL zero_dt_len: got %0d expected 1", run);
                else n_pass++;
                run = 0;
            end
        end
    endtask

    task automatic test_short_pulse();
        int low_h = 0;
        bit saw_l = 1'b0;
        deadtime_cycles = 16'd5; pwm_raw = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        pwm_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 1) pwm_raw = 1'b1;
            n_checks++;
            if (obs() !== expv()) $display("FAIL short_pulse: got %b expected %b", obs(), expv());
            else n_pass++;
            if (!out_h) low_h++;
            if (out_l) saw_l = 1'b1;
        end
        n_checks++;
        if (low_h != 5 || saw_l) $display("FAIL short_pulse_len: got low=%0d l_seen=%b expected low=5 l_seen=0", low_h, saw_l);
        else n_pass++;
    endtask

    task automatic test_dt_change();
        int len;
        deadtime_cycles = 16'd3; pwm_raw = 1'b0;
        tick();
        deadtime_cycles = 16'd8;
        len = 1;
        for (int i = 0; i < 20 && dt_active; i++) begin
            tick();
            if (dt_active) len++;
        end
        n_checks++;
        if (len != 3 || out_l !== 1'b1) $display("FAIL dt_change_first: got len=%0d l=%b expected len=3 l=1", len, out_l);
        else n_pass++;
        pwm_raw = 1'b1;
        len = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) $display("FAIL dt_change: got %b expected %b", obs(), expv());
            else n_pass++;
            if (dt_active) len++;
            if (out_h) break;
        end
        n_checks++;
        if (len != 8 || out_h !== 1'b1) $display("FAIL dt_change_second: got len=%0d h=%b expected len=8 h=1", len, out_h);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        int len = 0;
        deadtime_cycles = 16'd5; pwm_raw = 1'b0;
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        n_checks++;
        if (obs() !== 3'b000) $display("FAIL enable_drop: got %b expected 000", obs());
        else n_pass++;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (obs() !== expv()) $display("FAIL enable_restart: got %b expected %b", obs(), expv());
            else n_pass++;
            if (dt_active) len++;
            if (out_l) break;
        end
        n_checks++;
        if (len != 5 || out_l !== 1'b1) $display("FAIL enable_restart_len: got len=%0d l=%b expected len=5 l=1", len, out_l);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) pwm_raw = ~pwm_raw;
            if ($urandom_range(0, 40) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 15) == 0) deadtime_cycles = DTW'($urandom_range(0, 6));
            tick();
            n_checks++;
            if (obs() !== expv() || (out_h && out_l)) $display("FAIL random_cycle%0d: got %b expected %b", i, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_dt();
        test_short_pulse();
        test_dt_change();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
